m_stopwatch_ctrl: RTL and testbench
===================================

M_STOPWATCH_CTRL -- requirements
Module: m_stopwatch_ctrl

Interface
REQ-001 Parameter DIV, default 5000000, is the clk cycles per 0.1 s tick.
REQ-002 Parameter SEC_MAX, default 999, is the largest seconds value before wrap.
REQ-003 The port list SHALL be, clock and reset first:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_ss  in  1  start/stop request, active-high, synchronous level.
- btn_lap  in  1  lap request, active-high, synchronous level.
- btn_clr  in  1  clear request, active-high, synchronous level.
- tick  out  1  one-cycle pulse per counted 0.1 s.
- running  out  1  high in RUN or LAP.
- lap_active  out  1  high in LAP.
- ovf  out  1  sticky wrap flag.
- disp_tenths  out  4  displayed tenths, 0..9.
- disp_sec  out  10  displayed seconds, 0..SEC_MAX.

Function
REQ-004 Each button SHALL be registered once; event = current & ~previous; events act one cycle after the rising level.
REQ-005 The FSM SHALL have states IDLE, RUN, LAP and PAUSE.
REQ-006 IDLE: ss event -> RUN; other events ignored.
REQ-007 RUN: ss -> PAUSE; lap -> LAP with snapshot; clr ignored.
REQ-008 LAP: lap -> RUN; ss -> PAUSE; clr ignored.
REQ-009 PAUSE: ss -> RUN; clr -> IDLE with counters, prescaler and ovf zeroed; lap ignored.
REQ-010 Simultaneous events SHALL resolve by priority ss > lap > clr; only the winning applicable event acts and the rest are dropped.
REQ-011 The prescaler SHALL count 0..DIV-1 while state is RUN or LAP.
- tick = 1 when the prescaler is at DIV-1 and state is RUN or LAP.
- The prescaler holds its value in PAUSE, so phase is preserved.
- The prescaler clears only on reset or clear.
REQ-012 Counting enable SHALL use the registered state, so a tick in the cycle the FSM leaves RUN/LAP is still counted.
REQ-013 On tick, tenths SHALL increment; when tenths=9, tenths->0 and sec increments.
REQ-014 When sec=SEC_MAX and tenths=9 and tick is high, both SHALL wrap to 0 and ovf SHALL set and stay set until clear or reset.
REQ-015 The snapshot SHALL capture pre-increment counter values of the event cycle.
REQ-016 Display output SHALL be the snapshot in LAP and the live counters in all other states; outputs are registered, one-cycle latency.

Reset
REQ-017 rst_n low SHALL asynchronously force:
- state IDLE;
- prescaler, counters, snapshot and edge registers 0;
- tick, running, lap_active, ovf 0;
- disp_tenths and disp_sec 0.
REQ-018 Reset mid-RUN SHALL discard all progress; after release, no event fires for a button held through reset.

Structure
REQ-019 State encoding, DIV and SEC_MAX defaults SHALL live in a shared package/include used by the timer family.
REQ-020 The prescaler SHALL be one sub-module, m_prescale_en, with enable and synchronous clear inputs and a terminal-count output.

Verification (DIV=4, SEC_MAX=2)
REQ-021 Release reset, ss pulse, run 40 cycles -> tick every 4 cycles; disp reaches 1.0 s; running=1.
REQ-022 RUN at 0.5, lap pulse, wait 12 cycles -> disp holds 0.5 while live reaches 0.8; second lap -> disp shows 0.8.
REQ-023 RUN, ss at prescaler=2 -> PAUSE, counters frozen; ss again -> first tick after 2 cycles (phase kept); clr in PAUSE -> IDLE, all 0.
REQ-024 Run to 2.9 then tick -> disp 0.0, ovf=1; ovf persists until clr from PAUSE.
REQ-025 ss and clr asserted on the same cycle in PAUSE -> RUN, counters not cleared; clr in RUN ignored.
REQ-026 Assert rst_n=0 mid-RUN at 1.3 -> all outputs 0 immediately; hold ss across release -> stays IDLE.

Source files
------------

// File: rtl/m_stopwatch_ctrl_pkg.sv
// Shared definitions for the timer family: stopwatch state encoding and default timing.
package m_stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_e;

  localparam int unsigned SW_DIV_DEFAULT     = 32'd5000000;
  localparam int unsigned SW_SEC_MAX_DEFAULT = 32'd999;

  function automatic logic sw_counting(input sw_state_e st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/m_stopwatch_ctrl_prescale.sv
// Enabled modulo-DIV prescaler; holds its phase while disabled, zeroed only by reset or clr.
module m_prescale_en
  import m_stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DIV = SW_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int unsigned W    = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [W-1:0] LAST = W'(DIV - 32'd1);
  localparam logic [W-1:0] ONE  = W'(32'd1);

  logic [W-1:0] cnt_r;

  // phase counter, frozen when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = en & (cnt_r == LAST);

endmodule

// File: rtl/m_stopwatch_ctrl.sv
// Stopwatch controller: start/stop, lap freeze and clear over a tenths/seconds counter.
module m_stopwatch_ctrl
  import m_stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DIV     = SW_DIV_DEFAULT,
  parameter int unsigned SEC_MAX = SW_SEC_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic       tick,
  output logic       running,
  output logic       lap_active,
  output logic       ovf,
  output logic [3:0] disp_tenths,
  output logic [9:0] disp_sec
);

  localparam logic [9:0] SEC_LAST = 10'(SEC_MAX);

  sw_state_e  state_r;
  logic       ss_q_r, lap_q_r, clr_q_r, armed_r;
  logic       ev_ss_s, ev_lap_s, ev_clr_s;
  logic       cnt_en_s, tc_s, clr_take_s;
  logic [3:0] tenths_r, snap_tenths_r, disp_tenths_r;
  logic [9:0] sec_r, snap_sec_r, disp_sec_r;
  logic       tick_r, running_r, lap_active_r, ovf_r;

  // button history; armed_r masks the first sample so a button held through reset never fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q_r  <= 1'b0;
      lap_q_r <= 1'b0;
      clr_q_r <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      ss_q_r  <= btn_ss;
      lap_q_r <= btn_lap;
      clr_q_r <= btn_clr;
      armed_r <= 1'b1;
    end
  end

  assign ev_ss_s    = armed_r & btn_ss  & ~ss_q_r;
  assign ev_lap_s   = armed_r & btn_lap & ~lap_q_r;
  assign ev_clr_s   = armed_r & btn_clr & ~clr_q_r;
  assign cnt_en_s   = sw_counting(state_r);
  assign clr_take_s = (state_r == ST_PAUSE) & ev_clr_s & ~ev_ss_s;

  m_prescale_en #(.DIV(DIV)) u_prescale (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en_s),
    .clr   (clr_take_s),
    .tc    (tc_s)
  );

  // control FSM; start/stop outranks lap, lap outranks clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      running_r     <= 1'b0;
      lap_active_r  <= 1'b0;
      snap_tenths_r <= 4'd0;
      snap_sec_r    <= 10'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ev_ss_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ev_ss_s) begin
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
          end else if (ev_lap_s) begin
            state_r       <= ST_LAP;
            lap_active_r  <= 1'b1;
            snap_tenths_r <= tenths_r;
            snap_sec_r    <= sec_r;
          end
        end
        ST_LAP: begin
          if (ev_ss_s) begin
            state_r      <= ST_PAUSE;
            running_r    <= 1'b0;
            lap_active_r <= 1'b0;
          end else if (ev_lap_s) begin
            state_r      <= ST_RUN;
            lap_active_r <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (ev_ss_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else if (ev_clr_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          running_r    <= 1'b0;
          lap_active_r <= 1'b0;
        end
      endcase
    end
  end

  // live tenths/seconds counter with sticky wrap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tenths_r <= 4'd0;
      sec_r    <= 10'd0;
      ovf_r    <= 1'b0;
    end else if (clr_take_s) begin
      tenths_r <= 4'd0;
      sec_r    <= 10'd0;
      ovf_r    <= 1'b0;
    end else if (tc_s) begin
      if (tenths_r == 4'd9) begin
        tenths_r <= 4'd0;
        if (sec_r == SEC_LAST) begin
          sec_r <= 10'd0;
          ovf_r <= 1'b1;
        end else begin
          sec_r <= sec_r + 10'd1;
        end
      end else begin
        tenths_r <= tenths_r + 4'd1;
      end
    end
  end

  // registered tick and display mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r        <= 1'b0;
      disp_tenths_r <= 4'd0;
      disp_sec_r    <= 10'd0;
    end else begin
      tick_r <= tc_s;
      if (state_r == ST_LAP) begin
        disp_tenths_r <= snap_tenths_r;
        disp_sec_r    <= snap_sec_r;
      end else begin
        disp_tenths_r <= tenths_r;
        disp_sec_r    <= sec_r;
      end
    end
  end

  assign tick        = tick_r;
  assign running     = running_r;
  assign lap_active  = lap_active_r;
  assign ovf         = ovf_r;
  assign disp_tenths = disp_tenths_r;
  assign disp_sec    = disp_sec_r;

endmodule

// File: tb/tb_m_stopwatch_ctrl.sv
// Directed bench for m_stopwatch_ctrl with DIV=4, SEC_MAX=2; inputs and samples on falling edges.
module tb_m_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clr = 1'b0;
  logic       tick, running, lap_active, ovf;
  logic [3:0] disp_tenths;
  logic [9:0] disp_sec;
  int         checks = 0;
  int         failures = 0;

  m_stopwatch_ctrl #(.DIV(4), .SEC_MAX(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_ss      (btn_ss),
    .btn_lap     (btn_lap),
    .btn_clr     (btn_clr),
    .tick        (tick),
    .running     (running),
    .lap_active  (lap_active),
    .ovf         (ovf),
    .disp_tenths (disp_tenths),
    .disp_sec    (disp_sec)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired before completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic press_ss();
    btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
  endtask

  task automatic press_lap();
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
  endtask

  task automatic press_clr();
    btn_clr = 1'b1; cyc(1); btn_clr = 1'b0;
  endtask

  task automatic test_reset();
    cyc(2);
    checks++;
    if ({tick, running, lap_active, ovf, disp_sec, disp_tenths} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected all zero", {tick, running, lap_active, ovf, disp_sec, disp_tenths});
    end
    rst_n = 1'b1;
    cyc(2);
    press_lap(); cyc(1); press_clr(); cyc(8);
    checks++;
    if ({tick, running, lap_active, disp_sec, disp_tenths} !== 17'd0) begin
      failures++;
      $display("FAIL idle_ignores_lap_clr: got %b expected all zero", {tick, running, lap_active, disp_sec, disp_tenths});
    end
  endtask

  task automatic test_run();
    int tick_cnt;
    do_reset();
    press_ss();
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL run_running: got %0b expected 1", running); end
    tick_cnt = 0;
    for (int k = 2; k <= 41; k++) begin
      cyc(1);
      if (tick === 1'b1) tick_cnt++;
      checks++;
      if (tick !== ((k % 4) == 1)) begin
        failures++;
        $display("FAIL run_tick_phase: cycle %0d got %0b expected %0b", k, tick, ((k % 4) == 1));
      end
    end
    checks++;
    if (tick_cnt != 10) begin failures++; $display("FAIL run_tick_count: got %0d expected 10", tick_cnt); end
    cyc(1);
    checks++;
    if (disp_sec !== 10'd1 || disp_tenths !== 4'd0 || running !== 1'b1) begin
      failures++;
      $display("FAIL run_disp_1s: got %0d.%0d run=%0b expected 1.0 run=1", disp_sec, disp_tenths, running);
    end
  endtask

  task automatic test_lap();
    do_reset();
    press_ss();
    cyc(20);
    press_lap();
    checks++;
    if (lap_active !== 1'b1 || running !== 1'b1) begin
      failures++;
      $display("FAIL lap_enter: got lap=%0b run=%0b expected lap=1 run=1", lap_active, running);
    end
    cyc(1);
    checks++;
    if (disp_sec !== 10'd0 || disp_tenths !== 4'd5) begin
      failures++;
      $display("FAIL lap_snapshot: got %0d.%0d expected 0.5", disp_sec, disp_tenths);
    end
    cyc(10);
    checks++;
    if (tick !== 1'b1 || disp_tenths !== 4'd5 || lap_active !== 1'b1) begin
      failures++;
      $display("FAIL lap_hold: got tick=%0b disp=%0d.%0d lap=%0b expected tick=1 disp=0.5 lap=1",
               tick, disp_sec, disp_tenths, lap_active);
    end
    cyc(1);
    press_lap();
    cyc(1);
    checks++;
    if (disp_sec !== 10'd0 || disp_tenths !== 4'd8 || lap_active !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL lap_release: got %0d.%0d lap=%0b run=%0b expected 0.8 lap=0 run=1",
               disp_sec, disp_tenths, lap_active, running);
    end
  endtask

  task automatic test_pause_clear();
    int tick_cnt;
    do_reset();
    press_ss();
    cyc(13);
    press_ss();
    checks++;
    if (running !== 1'b0 || disp_tenths !== 4'd3) begin
      failures++;
      $display("FAIL pause_enter: got run=%0b tenths=%0d expected run=0 tenths=3", running, disp_tenths);
    end
    tick_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (tick !== 1'b0) tick_cnt++;
    end
    checks++;
    if (tick_cnt != 0 || disp_tenths !== 4'd3) begin
      failures++;
      $display("FAIL pause_frozen: got ticks=%0d tenths=%0d expected ticks=0 tenths=3", tick_cnt, disp_tenths);
    end
    press_ss();
    cyc(1);
    checks++;
    if (tick !== 1'b0) begin failures++; $display("FAIL resume_early_tick: got %0b expected 0", tick); end
    cyc(1);
    checks++;
    if (tick !== 1'b1) begin failures++; $display("FAIL resume_phase_tick: got %0b expected 1", tick); end
    cyc(1);
    checks++;
    if (disp_tenths !== 4'd4) begin failures++; $display("FAIL resume_count: got %0d expected 4", disp_tenths); end
    press_ss();
    press_clr();
    cyc(1);
    checks++;
    if ({tick, running, lap_active, ovf, disp_sec, disp_tenths} !== 18'd0) begin
      failures++;
      $display("FAIL clear_idle: got %b expected all zero", {tick, running, lap_active, ovf, disp_sec, disp_tenths});
    end
    press_ss();
    cyc(3);
    checks++;
    if (tick !== 1'b0) begin failures++; $display("FAIL clear_prescaler_early: got %0b expected 0", tick); end
    cyc(1);
    checks++;
    if (tick !== 1'b1) begin failures++; $display("FAIL clear_prescaler_tick: got %0b expected 1", tick); end
  endtask

  task automatic test_overflow();
    do_reset();
    press_ss();
    cyc(117);
    checks++;
    if (disp_sec !== 10'd2 || disp_tenths !== 4'd9 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_before: got %0d.%0d ovf=%0b expected 2.9 ovf=0", disp_sec, disp_tenths, ovf);
    end
    cyc(4);
    checks++;
    if (disp_sec !== 10'd0 || disp_tenths !== 4'd0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_wrap: got %0d.%0d ovf=%0b expected 0.0 ovf=1", disp_sec, disp_tenths, ovf);
    end
    cyc(8);
    checks++;
    if (disp_tenths !== 4'd2 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: got tenths=%0d ovf=%0b expected tenths=2 ovf=1", disp_tenths, ovf);
    end
    press_ss();
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_pause: got %0b expected 1", ovf); end
    press_clr();
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %0b expected 0", ovf); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press_ss();
    cyc(8);
    press_ss();
    cyc(1);
    btn_ss = 1'b1; btn_clr = 1'b1;
    cyc(1);
    btn_ss = 1'b0; btn_clr = 1'b0;
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL simul_ss_wins: got run=%0b expected 1", running); end
    cyc(1);
    checks++;
    if (disp_tenths !== 4'd2) begin failures++; $display("FAIL simul_no_clear: got %0d expected 2", disp_tenths); end
    press_clr();
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL run_clr_ignored: got run=%0b expected 1", running); end
    cyc(2);
    checks++;
    if (disp_sec !== 10'd0 || disp_tenths !== 4'd3) begin
      failures++;
      $display("FAIL run_clr_counting: got %0d.%0d expected 0.3", disp_sec, disp_tenths);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    press_ss();
    cyc(53);
    checks++;
    if (disp_sec !== 10'd1 || disp_tenths !== 4'd3) begin
      failures++;
      $display("FAIL midrun_value: got %0d.%0d expected 1.3", disp_sec, disp_tenths);
    end
    #2;
    rst_n = 1'b0;
    btn_ss = 1'b1;
    #1;
    checks++;
    if ({tick, running, lap_active, ovf, disp_sec, disp_tenths} !== 18'd0) begin
      failures++;
      $display("FAIL async_reset: got %b expected all zero", {tick, running, lap_active, ovf, disp_sec, disp_tenths});
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    checks++;
    if (running !== 1'b0 || disp_tenths !== 4'd0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL held_button_no_event: got run=%0b tenths=%0d tick=%0b expected 0 0 0", running, disp_tenths, tick);
    end
    btn_ss = 1'b0;
    cyc(1);
    press_ss();
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL restart_after_reset: got %0b expected 1", running); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_lap();
    test_pause_clear();
    test_overflow();
    test_simultaneous();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
